// File: rtl/bcd2b_seq.sv
// Sequential multi-digit BCD-to-binary converter.
// A packed BCD word is accepted on an input valid/ready handshake, then one
// digit is folded in per clock (most significant first) as acc = acc*10 + d.
// The result and a sticky invalid-digit flag are held on an output valid/ready
// handshake until the consumer takes them.
module bcd2b_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_W-1:0]      bin,
  output logic                  invalid,
  output logic                  busy
);

  // 10^n evaluated at elaboration time for the width check below.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // The result register must be wide enough for the largest decimal value
  // (all nines), which also rules out any need for saturation.
  generate
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd2b_seq: DIGITS must be in 1..8");
    end
    if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : g_bad_width
      $error("bcd2b_seq: BIN_W too small for DIGITS");
    end
  endgenerate

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [4*DIGITS-1:0]   shift_reg;
  logic [BIN_W-1:0]      acc_reg;
  logic                  err_reg;
  logic [BIN_W-1:0]      bin_reg;
  logic                  invalid_reg;
  logic                  out_valid_reg;

  logic [3:0]            digit;
  logic                  digit_bad;
  logic [BIN_W-1:0]      acc_next;
  logic                  err_next;
  logic [4*DIGITS-1:0]   shift_next;

  // Per-digit datapath: top nibble, its validity, and the next accumulator.
  always_comb begin
    digit     = shift_reg[4*DIGITS-1 -: 4];
    digit_bad = digit[3] & (digit[2] | digit[1]);
    acc_next  = (acc_reg << 3) + (acc_reg << 1) + BIN_W'(digit);
    err_next  = err_reg | digit_bad;
  end

  // Shift left by one nibble; the vacated low nibble fills with zero.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_shift
      if (gi == 0) begin : g_low
        assign shift_next[3:0] = 4'b0000;
      end else begin : g_mid
        assign shift_next[4*gi+3 -: 4] = shift_reg[4*gi-1 -: 4];
      end
    end
  endgenerate

  // Control FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      acc_reg       <= '0;
      err_reg       <= 1'b0;
      bin_reg       <= '0;
      invalid_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            shift_reg <= bcd;
            acc_reg   <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= CNT_W'(DIGITS - 1);
            state_reg <= S_CONV;
          end
        end
        S_CONV: begin
          shift_reg <= shift_next;
          acc_reg   <= acc_next;
          err_reg   <= err_next;
          if (cnt_reg == '0) begin
            // A bad digit anywhere forces the result to zero so a consumer
            // that ignores the flag never sees a plausible-looking number.
            bin_reg       <= err_next ? '0 : acc_next;
            invalid_reg   <= err_next;
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Handshake status decoded directly from the state register.
  assign in_ready  = (state_reg == S_IDLE);
  assign busy      = (state_reg == S_CONV) || (state_reg == S_DONE);
  assign out_valid = out_valid_reg;
  assign bin       = bin_reg;
  assign invalid   = invalid_reg;

endmodule

// File: tb/tb_bcd2b_seq.sv
// Directed bench for bcd2b_seq: a 4-digit instance for the main cases and a
// 1-digit instance for the single-digit regression sweep.
module tb_bcd2b_seq;

  logic        clk;
  logic        rst_n;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, invalid4, busy4;
  logic [15:0] bcd4;
  logic [13:0] bin4;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, invalid1, busy1;
  logic [3:0]  bcd1;
  logic [3:0]  bin1;

  int tests_run;
  int tests_failed;

  bcd2b_seq #(.DIGITS(4), .BIN_W(14)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .bcd(bcd4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .bin(bin4), .invalid(invalid4), .busy(busy4)
  );

  bcd2b_seq #(.DIGITS(1), .BIN_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .bcd(bcd1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .bin(bin1), .invalid(invalid1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One 4-digit conversion; completes the output handshake if out_ready4=1.
  task automatic run4(input string tag, input logic [15:0] word,
                      input logic [13:0] exp_bin, input logic exp_inv);
    int n;
    check({tag, " in_ready before"}, 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1;
    bcd4      = word;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check({tag, " busy"}, 32'(busy4), 32'd1);
    check({tag, " in_ready busy"}, 32'(in_ready4), 32'd0);
    n = 1;
    while (!out_valid4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd5);
    check({tag, " bin"}, 32'(bin4), 32'(exp_bin));
    check({tag, " invalid"}, 32'(invalid4), 32'(exp_inv));
    $display("[TB] d4 bcd=%h -> bin=%0d invalid=%0d latency=%0d", word, bin4, invalid4, n);
    if (out_ready4) begin
      @(posedge clk); #1;
      check({tag, " out_valid cleared"}, 32'(out_valid4), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready4), 32'd1);
    end
  endtask

  // One 1-digit conversion with the output handshake completed.
  task automatic run1(input logic [3:0] word, input logic [3:0] exp_bin, input logic exp_inv);
    int n;
    in_valid1 = 1'b1;
    bcd1      = word;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    n = 1;
    while (!out_valid1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("d1 latency", 32'(n), 32'd2);
    check("d1 bin", 32'(bin1), 32'(exp_bin));
    check("d1 invalid", 32'(invalid1), 32'(exp_inv));
    $display("[TB] d1 bcd=%0d -> bin=%0d invalid=%0d latency=%0d", word, bin1, invalid1, n);
    @(posedge clk); #1;
    check("d1 out_valid cleared", 32'(out_valid1), 32'd0);
  endtask

  initial begin
    int seen;
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    in_valid4  = 1'b0; bcd4 = '0; out_ready4 = 1'b1;
    in_valid1  = 1'b0; bcd1 = '0; out_ready1 = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst bin", 32'(bin4), 32'd0);
    check("rst invalid", 32'(invalid4), 32'd0);
    check("rst out_valid", 32'(out_valid4), 32'd0);
    check("rst busy", 32'(busy4), 32'd0);
    check("rst in_ready", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;

    // Valid and invalid words
    run4("9999", 16'h9999, 14'd9999, 1'b0);
    run4("1234", 16'h1234, 14'd1234, 1'b0);
    run4("0000", 16'h0000, 14'd0, 1'b0);
    run4("12A4", 16'h12A4, 14'd0, 1'b1);
    run4("F000", 16'hF000, 14'd0, 1'b1);

    // Backpressure: hold result while in_valid pulses with another word
    out_ready4 = 1'b0;
    run4("0042", 16'h0042, 14'd42, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid4 = i[0];
      bcd4      = 16'h0001;
      @(posedge clk); #1;
      check("bp bin", 32'(bin4), 32'd42);
      check("bp out_valid", 32'(out_valid4), 32'd1);
      check("bp in_ready", 32'(in_ready4), 32'd0);
    end
    in_valid4  = 1'b0;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", 32'(out_valid4), 32'd0);
    check("bp release in_ready", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;
    check("bp word not captured", 32'(busy4), 32'd0);
    check("bp bin kept", 32'(bin4), 32'd42);
    $display("[TB] d4 backpressure hold of 10 cycles done");

    // Mid-operation reset
    in_valid4 = 1'b1;
    bcd4      = 16'h5678;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(out_valid4), 32'd0);
    check("midrst busy", 32'(busy4), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid4) seen++;
    end
    check("midrst no result", 32'(seen), 32'd0);
    $display("[TB] d4 reset during 5678 conversion, no result emitted");
    run4("0777", 16'h0777, 14'd777, 1'b0);

    // Single-digit sweep
    for (int v = 0; v < 16; v++) begin
      if (v <= 9) run1(4'(v), 4'(v), 1'b0);
      else        run1(4'(v), 4'd0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
